// File: rtl/fir_mac_par.sv
// fir_mac_par: LANES-wide FIR multiply-accumulate with pipelined adder tree, convergent rounding and saturation
//   in : clock, reset (sync, active-low), datain_ready, coefs_in / datain (lane 0 in the MS slice)
//   out: addr_coefs/addr_data/rd_en to both memories, busy, dataout/dataout_ready/overflow result, overrun
module fir_mac_par #(
    parameter int LANES     = 8,
    parameter int DATA_W    = 18,
    parameter int COEF_W    = 36,
    parameter int NWORDS    = 2048,
    parameter int ADDR_W    = 11,
    parameter int MEM_LAT   = 1,
    parameter int ACC_W     = 64,
    parameter int FRAC_BITS = 35,
    parameter int SAT_EN    = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       datain_ready,
    input  logic [LANES*COEF_W-1:0]    coefs_in,
    input  logic [LANES*DATA_W-1:0]    datain,
    output logic [ADDR_W-1:0]          addr_coefs,
    output logic [ADDR_W-1:0]          addr_data,
    output logic                       rd_en,
    output logic                       busy,
    output logic signed [DATA_W-1:0]   dataout,
    output logic                       dataout_ready,
    output logic                       overflow,
    output logic                       overrun
);
    localparam int S  = $clog2(LANES);
    localparam int TW = ACC_W + S;
    localparam int PW = DATA_W + COEF_W;
    localparam int LP = MEM_LAT + 2 + S;
    localparam logic [ADDR_W-1:0]    LASTA = ADDR_W'(NWORDS - 1);
    localparam logic signed [TW:0]   MAXV  = {{(TW-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [TW:0]   MINV  = {{(TW-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [TW-1:0]        LMASK = (TW'(1) << (FRAC_BITS - 1)) - TW'(1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                    r_state;
    logic [ADDR_W-1:0]         r_addr;
    logic                      r_rd, r_busy, r_rdy, r_ovf;
    logic signed [DATA_W-1:0]  r_dout;
    logic [MEM_LAT:0]          r_vp, r_fp;
    logic [LP-1:0]             r_lp;
    logic signed [PW-1:0]      r_prod [LANES];
    // heap-ordered tree: node 1 is the root, nodes LANES..2*LANES-1 are the lane accumulators
    logic signed [TW-1:0]      r_node [1:2*LANES-1];

    logic signed [DATA_W-1:0]  w_d [LANES];
    logic signed [COEF_W-1:0]  w_c [LANES];
    logic signed [ACC_W-1:0]   w_acc [LANES];
    logic signed [TW-1:0]      w_s;
    logic signed [TW:0]        w_q, w_qr;
    logic                      w_inc, w_hi, w_lo;
    logic signed [DATA_W-1:0]  w_out;

    assign addr_coefs    = r_addr;
    assign addr_data     = r_addr;
    assign rd_en         = r_rd;
    assign busy          = r_busy;
    assign dataout       = r_dout;
    assign dataout_ready = r_rdy;
    assign overflow      = r_ovf;
    assign overrun       = datain_ready && r_busy;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_d[i]   = datain[(LANES-1-i)*DATA_W +: DATA_W];
            w_c[i]   = coefs_in[(LANES-1-i)*COEF_W +: COEF_W];
            // word 0 loads the product so no clear cycle is needed between samples
            w_acc[i] = r_fp[MEM_LAT] ? ACC_W'(r_prod[i]) : r_node[LANES+i][ACC_W-1:0] + ACC_W'(r_prod[i]);
        end
    end

    assign w_s   = r_node[1];
    assign w_q   = $signed({w_s[TW-1], w_s}) >>> FRAC_BITS;
    assign w_inc = w_s[FRAC_BITS-1] & ((|(w_s & LMASK)) | w_q[0]);
    assign w_qr  = w_q + (TW+1)'(w_inc);
    assign w_hi  = w_qr > MAXV;
    assign w_lo  = w_qr < MINV;
    assign w_out = (SAT_EN != 0 && w_hi) ? MAXV[DATA_W-1:0] :
                   (SAT_EN != 0 && w_lo) ? MINV[DATA_W-1:0] : w_qr[DATA_W-1:0];

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_rd    <= 1'b0;
            r_busy  <= 1'b0;
            r_rdy   <= 1'b0;
            r_ovf   <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_rdy <= 1'b0;
            case (r_state)
                IDLE: if (datain_ready) begin
                    r_state <= FETCH;
                    r_addr  <= '0;
                    r_rd    <= 1'b1;
                    r_busy  <= 1'b1;
                end
                FETCH: if (r_addr == LASTA) begin
                    r_rd    <= 1'b0;
                    r_state <= DRAIN;
                end else begin
                    r_addr <= r_addr + 1'b1;
                end
                DRAIN: if (r_lp[LP-1]) begin
                    r_state <= DONE;
                    r_rdy   <= 1'b1;
                    r_dout  <= w_out;
                    r_ovf   <= w_hi || w_lo;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_vp <= '0;
            r_fp <= '0;
            r_lp <= '0;
            for (int i = 0; i < LANES; i++) r_prod[i] <= '0;
            for (int n = 1; n < 2*LANES; n++) r_node[n] <= '0;
        end else begin
            // read-valid / first-word markers line up with memory data, then with the product register
            r_vp <= {r_vp[MEM_LAT-1:0], r_rd};
            r_fp <= {r_fp[MEM_LAT-1:0], r_rd && r_addr == '0};
            // last-word marker tracks the final word through memory, product, accumulate and tree stages
            r_lp <= {r_lp[LP-2:0], r_rd && r_addr == LASTA};
            for (int i = 0; i < LANES; i++) begin
                r_prod[i] <= PW'(w_d[i]) * PW'(w_c[i]);
                if (r_vp[MEM_LAT]) r_node[LANES+i] <= TW'(w_acc[i]);
            end
            for (int n = 1; n < LANES; n++) r_node[n] <= r_node[2*n] + r_node[2*n+1];
        end
    end
endmodule

// File: tb/tb_fir_mac_par.sv
// tb_fir_mac_par: directed checks of fir_mac_par in four configurations against hand-computed results
module tb_fir_mac_par;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, dr;
    int   sel;
    int   n_tests = 0, n_fail = 0;

    // A: default configuration
    logic [287:0] a_cmem [2048];
    logic [143:0] a_dmem [2048];
    logic [287:0] a_ci;
    logic [143:0] a_di;
    logic [10:0]  a_ac, a_ad;
    logic a_rd, a_busy, a_rdy, a_ovf, a_ovr;
    logic signed [17:0] a_out;

    fir_mac_par u_a (
        .clock(clk), .reset(rst_n), .datain_ready(dr && sel == 0),
        .coefs_in(a_ci), .datain(a_di), .addr_coefs(a_ac), .addr_data(a_ad),
        .rd_en(a_rd), .busy(a_busy), .dataout(a_out), .dataout_ready(a_rdy),
        .overflow(a_ovf), .overrun(a_ovr));

    always @(posedge clk) begin
        a_ci <= a_cmem[a_ac];
        a_di <= a_dmem[a_ad];
    end

    // B (saturating) and C (wrapping): 2 lanes, 4 words, sharing one memory image
    logic [71:0] bc_cmem [4];
    logic [35:0] bc_dmem [4];
    logic [71:0] b_ci, c_ci;
    logic [35:0] b_di, c_di;
    logic [1:0]  b_ac, b_ad, c_ac, c_ad;
    logic b_rd, b_busy, b_rdy, b_ovf, b_ovr, c_rd, c_busy, c_rdy, c_ovf, c_ovr;
    logic signed [17:0] b_out, c_out;

    fir_mac_par #(.LANES(2), .NWORDS(4), .ADDR_W(2), .SAT_EN(1)) u_b (
        .clock(clk), .reset(rst_n), .datain_ready(dr && sel == 1),
        .coefs_in(b_ci), .datain(b_di), .addr_coefs(b_ac), .addr_data(b_ad),
        .rd_en(b_rd), .busy(b_busy), .dataout(b_out), .dataout_ready(b_rdy),
        .overflow(b_ovf), .overrun(b_ovr));

    fir_mac_par #(.LANES(2), .NWORDS(4), .ADDR_W(2), .SAT_EN(0)) u_c (
        .clock(clk), .reset(rst_n), .datain_ready(dr && sel == 2),
        .coefs_in(c_ci), .datain(c_di), .addr_coefs(c_ac), .addr_data(c_ad),
        .rd_en(c_rd), .busy(c_busy), .dataout(c_out), .dataout_ready(c_rdy),
        .overflow(c_ovf), .overrun(c_ovr));

    always @(posedge clk) begin
        b_ci <= bc_cmem[b_ac];
        b_di <= bc_dmem[b_ad];
        c_ci <= bc_cmem[c_ac];
        c_di <= bc_dmem[c_ad];
    end

    // D: 16 lanes, 8 words, 3-cycle memory
    logic [575:0] d_cmem [8];
    logic [287:0] d_dmem [8];
    logic [575:0] d_c1, d_c2, d_ci;
    logic [287:0] d_d1, d_d2, d_di;
    logic [2:0]   d_ac, d_ad;
    logic d_rd, d_busy, d_rdy, d_ovf, d_ovr;
    logic signed [17:0] d_out;

    fir_mac_par #(.LANES(16), .NWORDS(8), .ADDR_W(3), .MEM_LAT(3)) u_d (
        .clock(clk), .reset(rst_n), .datain_ready(dr && sel == 3),
        .coefs_in(d_ci), .datain(d_di), .addr_coefs(d_ac), .addr_data(d_ad),
        .rd_en(d_rd), .busy(d_busy), .dataout(d_out), .dataout_ready(d_rdy),
        .overflow(d_ovf), .overrun(d_ovr));

    always @(posedge clk) begin
        d_c1 <= d_cmem[d_ac];
        d_c2 <= d_c1;
        d_ci <= d_c2;
        d_d1 <= d_dmem[d_ad];
        d_d2 <= d_d1;
        d_di <= d_d2;
    end

    logic m_rdy, m_ovf, m_ovr, m_busy;
    logic signed [17:0] m_out;
    assign m_rdy  = sel == 0 ? a_rdy  : sel == 1 ? b_rdy  : sel == 2 ? c_rdy  : d_rdy;
    assign m_ovf  = sel == 0 ? a_ovf  : sel == 1 ? b_ovf  : sel == 2 ? c_ovf  : d_ovf;
    assign m_ovr  = sel == 0 ? a_ovr  : sel == 1 ? b_ovr  : sel == 2 ? c_ovr  : d_ovr;
    assign m_busy = sel == 0 ? a_busy : sel == 1 ? b_busy : sel == 2 ? c_busy : d_busy;
    assign m_out  = sel == 0 ? a_out  : sel == 1 ? b_out  : sel == 2 ? c_out  : d_out;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input int lat, input longint eo, input longint ev);
        int n, ae, ac;
        n = 0; ae = 0; ac = 0;
        @(posedge clk); #1 dr = 1'b1;
        @(negedge clk);
        chk({tag, "_ovr_idle"}, m_ovr, 0);
        @(posedge clk); #1 dr = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) chk({tag, "_busy"}, m_busy, 1);
            if (sel == 0 && a_rd) begin
                if (a_ac != 11'(ac) || a_ad != 11'(ac)) ae++;
                ac++;
            end
        end while (!m_rdy && n < lat + 20);
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_out"}, m_out, eo);
        chk({tag, "_ovf"}, m_ovf, ev);
        if (sel == 0) begin
            chk({tag, "_addr_err"}, ae, 0);
            chk({tag, "_rd_cnt"}, ac, 2048);
        end
        @(negedge clk);
        chk({tag, "_rdy_pulse"}, m_rdy, 0);
        chk({tag, "_busy_off"}, m_busy, 0);
    endtask

    task automatic ref_d(output longint o, output longint v);
        longint s, q, r, h;
        logic signed [17:0] dv;
        logic signed [35:0] cv;
        s = 0;
        h = 64'sd1 <<< 34;
        for (int w = 0; w < 8; w++)
            for (int l = 0; l < 16; l++) begin
                dv = d_dmem[w][(15-l)*18 +: 18];
                cv = d_cmem[w][(15-l)*36 +: 36];
                s += longint'(dv) * longint'(cv);
            end
        q = s >>> 35;
        r = s - (q <<< 35);
        if (r > h || (r == h && q[0])) q++;
        v = (q > 131071 || q < -131072) ? 1 : 0;
        o = q > 131071 ? 131071 : q < -131072 ? -131072 : q;
    endtask

    task automatic bc_round(input logic signed [17:0] d, input logic extra);
        for (int w = 0; w < 4; w++) begin
            bc_cmem[w] = '0;
            bc_dmem[w] = '0;
        end
        bc_cmem[0][71:36] = 36'h400000000;
        bc_dmem[0][35:18] = d;
        if (extra) begin
            bc_cmem[1][35:0] = 36'd1;
            bc_dmem[1][17:0] = 18'd1;
        end
    endtask

    task automatic bc_fill(input logic [17:0] d);
        for (int w = 0; w < 4; w++) begin
            bc_cmem[w] = {2{36'h400000000}};
            bc_dmem[w] = {2{d}};
        end
    endtask

    initial begin
        int rc, xo, lk, cnt;
        longint eo, ev;
        logic signed [27:0] t;
        dr = 1'b0; sel = 0; rst_n = 1'b0;
        for (int w = 0; w < 2048; w++) begin
            a_cmem[w] = '0;
            a_dmem[w] = {18'd1000, {7{18'd5}}};
        end
        a_cmem[0][287 -: 36]    = 36'h400000000;
        a_cmem[2047][287 -: 36] = 36'h400000000;
        bc_round(18'sd5, 1'b0);
        for (int w = 0; w < 8; w++) begin
            d_cmem[w] = '0;
            d_dmem[w] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out", a_out, 0);
        chk("rst_rdy", a_rdy, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_rd", a_rd, 0);
        chk("rst_addr", a_ac, 0);
        chk("rst_d_out", d_out, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // lane 0: 0.5*1000 at word 0 and at word 2047
        run("dflt", 2055, 1000, 0);

        // lane 7 contributes -0.5*500 at word 5
        a_cmem[5][35:0] = -36'sh400000000;
        for (int w = 0; w < 2048; w++) a_dmem[w][17:0] = 18'd500;
        run("lane7", 2055, 750, 0);

        // requests at T+10 and in DONE are dropped; DONE+1 starts a new sample
        rc = 0; xo = 0; lk = 0;
        @(posedge clk); #1 dr = 1'b1;
        @(negedge clk);
        chk("ovr_T", m_ovr, 0);
        for (int k = 1; k <= 4120; k++) begin
            @(posedge clk); #1 dr = (k == 10 || k == 2055 || k == 2056);
            @(negedge clk);
            if (k == 10) chk("ovr_busy", m_ovr, 1);
            else if (k == 2055) begin
                chk("ovr_done", m_ovr, 1);
                chk("rdy_at_done", m_rdy, 1);
            end
            else if (k == 2056) chk("ovr_idle", m_ovr, 0);
            else if (m_ovr) xo++;
            if (m_rdy) begin
                rc++;
                lk = k;
            end
        end
        dr = 1'b0;
        chk("ovr_extra", xo, 0);
        chk("rdy_count", rc, 2);
        chk("second_lat", lk, 4111);
        chk("second_out", m_out, 750);

        // reset mid-run, then a changed word 0 must not see stale accumulators
        @(posedge clk); #1 dr = 1'b1;
        @(posedge clk); #1 dr = 1'b0;
        repeat (99) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_out", a_out, 0);
        chk("abort_ovf", a_ovf, 0);
        chk("abort_busy", a_busy, 0);
        chk("abort_rd", a_rd, 0);
        cnt = 0;
        for (int k = 0; k < 2100; k++) begin
            @(negedge clk);
            if (a_rdy) cnt++;
        end
        chk("abort_no_rdy", cnt, 0);
        a_dmem[0][143 -: 18] = 18'd777;
        run("post_rst", 2055, 638, 0);

        sel = 1;
        bc_round(18'sd5, 1'b0);
        run("rnd_2p5", 9, 2, 0);
        bc_round(18'sd7, 1'b0);
        run("rnd_3p5", 9, 4, 0);
        bc_round(-18'sd5, 1'b0);
        run("rnd_m2p5", 9, -2, 0);
        bc_round(18'sd5, 1'b1);
        run("rnd_2p5_lsb", 9, 3, 0);

        bc_fill(18'h1FFFF);
        run("sat_pos", 9, 131071, 1);
        sel = 2;
        run("wrap_pos", 9, -4, 1);
        bc_fill(18'h20000);
        run("wrap_neg", 9, 0, 1);
        sel = 1;
        run("sat_neg", 9, -131072, 1);

        sel = 3;
        for (int r = 0; r < 2; r++) begin
            for (int w = 0; w < 8; w++)
                for (int l = 0; l < 16; l++) begin
                    t = 28'($urandom);
                    d_cmem[w][(15-l)*36 +: 36] = {{8{t[27]}}, t};
                    d_dmem[w][(15-l)*18 +: 18] = 18'($urandom);
                end
            ref_d(eo, ev);
            run(r == 0 ? "lat3_a" : "lat3_b", 18, eo, ev);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
